// File: rtl/versat_mem_np.sv
// N-port memory functional unit: per-port two-level address generators drive an
// external synchronous RAM; port 0 additionally serves a single-outstanding CPU databus.
module versat_mem_np #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int PERIOD_W  = 10,
   parameter int DELAY_W   = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          running,
   output logic                          done,
   input  logic                          valid,
   input  logic [DATA_W/8-1:0]           wstrb,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             wdata,
   output logic                          ready,
   output logic [DATA_W-1:0]             rdata,
   input  logic [NUM_PORTS*DATA_W-1:0]   in,
   output logic [NUM_PORTS*DATA_W-1:0]   out,
   output logic [NUM_PORTS*ADDR_W-1:0]   ext_addr,
   output logic [NUM_PORTS*DATA_W-1:0]   ext_wdata,
   output logic [NUM_PORTS-1:0]          ext_en,
   output logic [NUM_PORTS-1:0]          ext_we,
   input  logic [NUM_PORTS*DATA_W-1:0]   ext_rdata,
   input  logic [NUM_PORTS*ADDR_W-1:0]   iter,
   input  logic [NUM_PORTS*ADDR_W-1:0]   shift,
   input  logic [NUM_PORTS*ADDR_W-1:0]   incr,
   input  logic [NUM_PORTS*ADDR_W-1:0]   start,
   input  logic [NUM_PORTS*PERIOD_W-1:0] per,
   input  logic [NUM_PORTS*PERIOD_W-1:0] duty,
   input  logic [NUM_PORTS*DELAY_W-1:0]  delay,
   input  logic [NUM_PORTS-1:0]          wr,
   input  logic [NUM_PORTS-1:0]          ext,
   input  logic [NUM_PORTS-1:0]          rev
);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN} state_t;

   localparam logic [DELAY_W-1:0] DRAIN_CNT = DELAY_W'(2);

   logic                 bus_accept;
   logic                 bus_we;
   logic                 rd_p1;
   logic                 rd_p2;
   logic [NUM_PORTS-1:0] port_idle;

   // A new request waits until the previous one has fully completed, including its ready cycle.
   assign bus_we     = |wstrb;
   assign bus_accept = valid & ~running & ~rd_p1 & ~rd_p2 & ~ready;
   assign done       = (&port_idle) & ~run;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_p1 <= 1'b0;
         rd_p2 <= 1'b0;
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         rd_p1 <= bus_accept & ~bus_we;
         rd_p2 <= rd_p1;
         ready <= (bus_accept & bus_we) | rd_p2;
         rdata <= rd_p2 ? ext_rdata[DATA_W-1:0] : '0;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      state_t              state_q, state_d;
      logic [DELAY_W-1:0]  cnt_q, cnt_d;
      logic [PERIOD_W-1:0] j_q, j_d, per_q, duty_q;
      logic [ADDR_W-1:0]   i_q, i_d, addr_q, addr_d, addr_rev, eff_addr;
      logic [ADDR_W-1:0]   iter_q, shift_q, incr_q;
      logic                wr_q, ext_q, rev_q, step_en, cfg_empty;
      logic [DATA_W-1:0]   in_p, out_q, wdata_q;
      logic [ADDR_W-1:0]   ext_addr_q;
      logic                ext_en_q, ext_we_q;

      assign in_p      = in[p*DATA_W +: DATA_W];
      assign cfg_empty = (iter[p*ADDR_W +: ADDR_W] == '0) || (per[p*PERIOD_W +: PERIOD_W] == '0);

      // NOTE: configuration shadows carry no reset; they are always loaded by run before use.
      always_ff @(posedge clk) begin
         if (run) begin
            iter_q  <= iter[p*ADDR_W +: ADDR_W];
            shift_q <= shift[p*ADDR_W +: ADDR_W];
            incr_q  <= incr[p*ADDR_W +: ADDR_W];
            per_q   <= per[p*PERIOD_W +: PERIOD_W];
            duty_q  <= duty[p*PERIOD_W +: PERIOD_W];
            wr_q    <= wr[p];
            ext_q   <= ext[p];
            rev_q   <= rev[p];
         end
      end

      // NOTE: every variable gets a default at the top so no path can infer a latch.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         j_d     = j_q;
         i_d     = i_q;
         addr_d  = addr_q;
         step_en = 1'b0;
         case (state_q)
            S_DELAY: begin
               cnt_d = cnt_q - DELAY_W'(1);
               if (cnt_q <= DELAY_W'(1)) begin
                  if (iter_q == '0 || per_q == '0) begin
                     state_d = S_DRAIN;
                     cnt_d   = DRAIN_CNT;
                  end else begin
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               // The address advances every cycle; duty only gates the RAM enable.
               step_en = (j_q < duty_q);
               addr_d  = addr_q + incr_q;
               j_d     = j_q + PERIOD_W'(1);
               if (j_q == per_q - PERIOD_W'(1)) begin
                  addr_d = addr_q + incr_q + shift_q;
                  j_d    = '0;
                  i_d    = i_q + ADDR_W'(1);
                  if (i_q == iter_q - ADDR_W'(1)) begin
                     state_d = S_DRAIN;
                     cnt_d   = DRAIN_CNT;
                  end
               end
            end
            S_DRAIN: begin
               cnt_d = cnt_q - DELAY_W'(1);
               if (cnt_q == '0) state_d = S_IDLE;
            end
            default: ;
         endcase
         if (run) begin
            step_en = 1'b0;
            j_d     = '0;
            i_d     = '0;
            addr_d  = start[p*ADDR_W +: ADDR_W];
            cnt_d   = delay[p*DELAY_W +: DELAY_W];
            if (delay[p*DELAY_W +: DELAY_W] != '0) begin
               state_d = S_DELAY;
            end else if (cfg_empty) begin
               state_d = S_DRAIN;
               cnt_d   = DRAIN_CNT;
            end else begin
               state_d = S_RUN;
            end
         end
      end

      always_comb begin
         for (int b = 0; b < ADDR_W; b++) addr_rev[b] = addr_q[ADDR_W-1-b];
      end

      assign eff_addr = ext_q ? in_p[ADDR_W-1:0] : (rev_q ? addr_rev : addr_q);

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            j_q        <= '0;
            i_q        <= '0;
            addr_q     <= '0;
            ext_en_q   <= 1'b0;
            ext_we_q   <= 1'b0;
            ext_addr_q <= '0;
            wdata_q    <= '0;
            out_q      <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            i_q     <= i_d;
            addr_q  <= addr_d;
            out_q   <= run ? '0 : ext_rdata[p*DATA_W +: DATA_W];
            if (p == 0 && bus_accept) begin
               ext_en_q   <= 1'b1;
               ext_we_q   <= bus_we;
               ext_addr_q <= addr;
               wdata_q    <= wdata;
            end else begin
               ext_en_q <= step_en;
               ext_we_q <= step_en & wr_q & ~ext_q;
               if (step_en) begin
                  ext_addr_q <= eff_addr;
                  wdata_q    <= in_p;
               end
            end
         end
      end

      assign port_idle[p]                   = (state_q == S_IDLE);
      assign ext_en[p]                      = ext_en_q;
      assign ext_we[p]                      = ext_we_q;
      assign ext_addr[p*ADDR_W +: ADDR_W]   = ext_addr_q;
      assign ext_wdata[p*DATA_W +: DATA_W]  = wdata_q;
      assign out[p*DATA_W +: DATA_W]        = out_q;
   end

endmodule
